// File: rtl/music_box_pkg.sv
// Shared types and constants for the music-box state blocks.
package music_box_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      LOAD  = 3'd2,
      PLAY  = 3'd3,
      GAP   = 3'd4,
      DONE  = 3'd5
   } state_t;

   // Clock cycles per tick, never below 1 so the prescaler always has a valid terminal count.
   function automatic int unsigned tick_div(input int unsigned clk_hz, input int unsigned tick_hz);
      int unsigned d;
      d = (tick_hz == 0) ? 1 : clk_hz / tick_hz;
      return (d == 0) ? 1 : d;
   endfunction

   localparam int unsigned TICK_DIV = tick_div(50_000_000, 1000);

endpackage

// File: rtl/music_box_state_play_song_tick_generator.sv
// Prescaler: counts 0..DIV-1 while enabled; tick marks the wrapping cycle.
module tick_generator
   import music_box_pkg::*;
#(
   parameter int unsigned DIV = TICK_DIV
) (
   input  logic clock_50Mhz,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   output logic tick
);

   localparam int unsigned     CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] count;

   assign tick = enable && (count == LAST);

   always_ff @(posedge clock_50Mhz) begin
      if (reset || clear) begin
         count <= '0;
      end else if (enable) begin
         count <= tick ? '0 : count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/music_box_state_play_song.sv
// Song player: walks an external note/duration memory, sounding each note then a silent gap.
module music_box_state_play_song
   import music_box_pkg::*;
#(
   parameter logic [4:0]  STATE_ID  = 5'd2,
   parameter int unsigned CLK_HZ    = 50_000_000,
   parameter int unsigned TICK_HZ   = 1000,
   parameter int unsigned ADDR_W    = 6,
   parameter int unsigned NOTE_W    = 8,
   parameter int unsigned DUR_W     = 16,
   parameter int unsigned GAP_TICKS = 20
) (
   input  logic              clock_50Mhz,
   input  logic              reset,
   input  logic [4:0]        currentState,
   input  logic              pause,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [NOTE_W-1:0] mem_note,
   input  logic [DUR_W-1:0]  mem_dur,
   output logic [NOTE_W-1:0] note_code,
   output logic              note_on,
   output logic              stateComplete,
   output logic [31:0]       debugString
);

   localparam int unsigned      DIV      = tick_div(CLK_HZ, TICK_HZ);
   localparam logic [DUR_W-1:0] GAP_LOAD = DUR_W'(GAP_TICKS);

   state_t              state, state_n;
   logic [ADDR_W-1:0]   index, index_n;
   logic [DUR_W-1:0]    remaining, remaining_n;
   logic [NOTE_W-1:0]   note_code_n;
   logic                active;
   logic                tick;
   logic                next_note;

   assign active = (currentState == STATE_ID);

   tick_generator #(.DIV(DIV)) u_tick (
      .clock_50Mhz (clock_50Mhz),
      .reset       (reset),
      .enable      ((state == PLAY || state == GAP) && !pause),
      .clear       (state == LOAD),
      .tick        (tick)
   );

   // Next-state and datapath updates
   always_comb begin
      state_n     = state;
      index_n     = index;
      remaining_n = remaining;
      note_code_n = note_code;
      next_note   = 1'b0;

      case (state)
         IDLE: begin
            if (active) begin
               state_n = FETCH;
               index_n = '0;
            end
         end
         FETCH: state_n = LOAD;
         LOAD: begin
            if (mem_dur == '0) begin
               state_n = DONE;
            end else begin
               note_code_n = mem_note;
               remaining_n = mem_dur;
               state_n     = PLAY;
            end
         end
         PLAY: begin
            if (tick) begin
               if (remaining == DUR_W'(1)) begin
                  if (GAP_LOAD == '0) begin
                     next_note = 1'b1;
                  end else begin
                     remaining_n = GAP_LOAD;
                     state_n     = GAP;
                  end
               end else begin
                  remaining_n = remaining - DUR_W'(1);
               end
            end
         end
         GAP: begin
            if (tick) begin
               if (remaining == DUR_W'(1)) begin
                  next_note = 1'b1;
               end else begin
                  remaining_n = remaining - DUR_W'(1);
               end
            end
         end
         DONE: state_n = DONE;
         default: state_n = IDLE;
      endcase

      // Last address ends the song without a further fetch
      if (next_note) begin
         remaining_n = '0;
         if (index == '1) begin
            state_n = DONE;
         end else begin
            index_n = index + ADDR_W'(1);
            state_n = FETCH;
         end
      end

      if (!active) begin
         state_n = IDLE;
         index_n = '0;
      end
   end

   always_ff @(posedge clock_50Mhz) begin
      if (reset) begin
         state         <= IDLE;
         index         <= '0;
         remaining     <= '0;
         note_code     <= '0;
         stateComplete <= 1'b0;
      end else begin
         state         <= state_n;
         index         <= index_n;
         remaining     <= remaining_n;
         note_code     <= note_code_n;
         stateComplete <= (state_n == DONE);
      end
   end

   // index only moves on entry to FETCH, so it is stable for the whole fetch cycle
   assign mem_addr    = index;
   assign note_on     = (state == PLAY) && !pause;
   assign debugString = {2'b00, state, 11'(index), 16'(remaining)};

endmodule

// File: tb/tb_music_box_state_play_song.sv
// Bench for music_box_state_play_song: expected note/gap/done events queued by stimulus, checked by a monitor.
module tb_music_box_state_play_song;

   localparam logic [1:0] K_RISE = 2'd0;
   localparam logic [1:0] K_FALL = 2'd1;
   localparam logic [1:0] K_DONE = 2'd2;

   typedef struct packed {
      logic [1:0]  kind;
      logic [7:0]  note;
      int unsigned val;
   } ev_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  currentState;
   logic        pause;
   logic [1:0]  mem_addr;
   logic [7:0]  mem_note;
   logic [15:0] mem_dur;
   logic [7:0]  note_code;
   logic        note_on;
   logic        stateComplete;
   logic [31:0] debugString;

   logic [7:0]  mem_n [4];
   logic [15:0] mem_d [4];

   ev_t sb[$];
   int  compared   = 0;
   int  mismatched = 0;
   int  cyc        = 0;
   int  act_cyc    = 0;
   int  run        = 0;
   logic prev_on   = 1'b0;
   logic prev_done = 1'b0;

   music_box_state_play_song #(
      .STATE_ID (5'd2), .CLK_HZ (100), .TICK_HZ (10), .ADDR_W (2),
      .NOTE_W (8), .DUR_W (16), .GAP_TICKS (2)
   ) dut (
      .clock_50Mhz   (clk),
      .reset         (reset),
      .currentState  (currentState),
      .pause         (pause),
      .mem_addr      (mem_addr),
      .mem_note      (mem_note),
      .mem_dur       (mem_dur),
      .note_code     (note_code),
      .note_on       (note_on),
      .stateComplete (stateComplete),
      .debugString   (debugString)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous song memory: data one cycle after the address
   always @(posedge clk) begin
      mem_note <= mem_n[mem_addr];
      mem_dur  <= mem_d[mem_addr];
   end

   task automatic observe(input logic [1:0] k, input logic [7:0] n, input int unsigned v);
      ev_t got, exp;
      got.kind = k; got.note = n; got.val = v;
      compared++;
      if (sb.size() == 0) begin
         mismatched++;
         $display("FAIL sb_unexpected: got kind=%0d note=%0d val=%0d, required no event", k, n, v);
      end else begin
         exp = sb.pop_front();
         if (got !== exp) begin
            mismatched++;
            $display("FAIL sb_event: got kind=%0d note=%0d val=%0d, required kind=%0d note=%0d val=%0d",
                     got.kind, got.note, got.val, exp.kind, exp.note, exp.val);
         end
      end
   endtask

   // Monitor: note_on rise (time since activation), fall (run length), stateComplete rise
   always @(negedge clk) begin
      if (note_on === 1'b1 && prev_on !== 1'b1) begin
         observe(K_RISE, note_code, cyc - act_cyc);
         run = 1;
      end else if (note_on === 1'b1) begin
         run++;
      end
      if (note_on === 1'b0 && prev_on === 1'b1) observe(K_FALL, note_code, run);
      if (stateComplete === 1'b1 && prev_done !== 1'b1) observe(K_DONE, 8'd0, cyc - act_cyc);
      prev_on   = note_on;
      prev_done = stateComplete;
   end

   task automatic expect_ev(input logic [1:0] k, input logic [7:0] n, input int unsigned v);
      ev_t e;
      e.kind = k; e.note = n; e.val = v;
      sb.push_back(e);
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) step();
   endtask

   task automatic load_mem(input logic [7:0] n0, input logic [15:0] d0, input logic [7:0] n1, input logic [15:0] d1,
                           input logic [7:0] n2, input logic [15:0] d2, input logic [7:0] n3, input logic [15:0] d3);
      mem_n[0] = n0; mem_d[0] = d0; mem_n[1] = n1; mem_d[1] = d1;
      mem_n[2] = n2; mem_d[2] = d2; mem_n[3] = n3; mem_d[3] = d3;
   endtask

   task automatic activate();
      currentState = 5'd2;
      act_cyc = cyc;
   endtask

   task automatic deactivate();
      currentState = 5'd0;
      step();
      step();
   endtask

   // Song {(5,3),(7,1),end}: 30 high, 20 gap + fetch + load, 10 high, gap, fetch, load, done
   task automatic push_song1();
      expect_ev(K_RISE, 8'd5, 3);
      expect_ev(K_FALL, 8'd5, 30);
      expect_ev(K_RISE, 8'd7, 55);
      expect_ev(K_FALL, 8'd7, 10);
      expect_ev(K_DONE, 8'd0, 87);
   endtask

   task automatic wait_done(input string name, input int limit);
      int k;
      k = 0;
      while (stateComplete !== 1'b1 && k < limit) begin
         step();
         k++;
      end
      if (stateComplete !== 1'b1) begin
         compared++;
         mismatched++;
         $display("FAIL %s_timeout: stateComplete=%b after %0d cycles, required 1", name, stateComplete, limit);
      end
      step();
      step();
      check({name, "_drained"}, 32'(sb.size()), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      currentState = 5'd0;
      pause = 1'b0;
      load_mem(8'd5, 16'd3, 8'd7, 16'd1, 8'd0, 16'd0, 8'd0, 16'd0);
      step(); step(); step();
      @(negedge clk);
      check("rst_note_on", 32'(note_on), 32'd0);
      check("rst_complete", 32'(stateComplete), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_note_code", 32'(note_code), 32'd0);
      check("rst_debug", debugString, 32'd0);
      step();
      reset = 1'b0;
      step();

      // Basic two-note song
      push_song1();
      activate();
      wait_done("song1", 200);
      deactivate();
      @(negedge clk);
      check("song1_complete_cleared", 32'(stateComplete), 32'd0);

      // Four nonzero entries: finish after entry 3's gap, no fifth fetch
      load_mem(8'd1, 16'd1, 8'd2, 16'd1, 8'd3, 16'd1, 8'd4, 16'd1);
      for (int i = 0; i < 4; i++) begin
         expect_ev(K_RISE, 8'(i + 1), 32'(3 + 32 * i));
         expect_ev(K_FALL, 8'(i + 1), 10);
      end
      expect_ev(K_DONE, 8'd0, 129);
      activate();
      wait_done("full", 300);
      check("full_last_addr", 32'(mem_addr), 32'd3);
      deactivate();

      // Pause 25 cycles inside note 5: 12 + 18 high cycles, done delayed by 25
      load_mem(8'd5, 16'd3, 8'd0, 16'd0, 8'd0, 16'd0, 8'd0, 16'd0);
      expect_ev(K_RISE, 8'd5, 3);
      expect_ev(K_FALL, 8'd5, 12);
      expect_ev(K_RISE, 8'd5, 40);
      expect_ev(K_FALL, 8'd5, 18);
      expect_ev(K_DONE, 8'd0, 80);
      activate();
      wait_until(act_cyc + 15);
      pause = 1'b1;
      wait_until(act_cyc + 20);
      @(negedge clk);
      check("pause_note_on", 32'(note_on), 32'd0);
      check("pause_debug", debugString, 32'h1800_0002);
      wait_until(act_cyc + 40);
      pause = 1'b0;
      wait_done("pause", 200);
      deactivate();

      // Deactivation mid-note, then a clean restart from index 0
      load_mem(8'd5, 16'd3, 8'd7, 16'd1, 8'd0, 16'd0, 8'd0, 16'd0);
      expect_ev(K_RISE, 8'd5, 3);
      expect_ev(K_FALL, 8'd5, 8);
      activate();
      wait_until(act_cyc + 10);
      currentState = 5'd0;
      step();
      @(negedge clk);
      check("deact_note_on", 32'(note_on), 32'd0);
      check("deact_complete", 32'(stateComplete), 32'd0);
      step();
      push_song1();
      activate();
      wait_done("reactivate", 200);
      deactivate();

      // Reset during the first gap while still active
      expect_ev(K_RISE, 8'd5, 3);
      expect_ev(K_FALL, 8'd5, 30);
      activate();
      wait_until(act_cyc + 40);
      reset = 1'b1;
      wait_until(act_cyc + 41);
      @(negedge clk);
      check("midrst_note_on", 32'(note_on), 32'd0);
      check("midrst_complete", 32'(stateComplete), 32'd0);
      check("midrst_note_code", 32'(note_code), 32'd0);
      check("midrst_debug", debugString, 32'd0);
      step();
      reset = 1'b0;
      act_cyc = cyc;
      push_song1();
      step();
      @(negedge clk);
      check("midrst_restart_addr", 32'(mem_addr), 32'd0);
      wait_done("midrst", 200);
      deactivate();

      // Empty song: done after fetch + load, no note
      load_mem(8'd9, 16'd0, 8'd7, 16'd1, 8'd0, 16'd0, 8'd0, 16'd0);
      expect_ev(K_DONE, 8'd0, 3);
      activate();
      wait_done("empty", 50);
      deactivate();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/music_box_state_play_song.md
MUSIC_BOX_STATE_PLAY_SONG -- requirements
Module: music_box_state_play_song

Interface
REQ-001 Parameter STATE_ID, default 5'd2: currentState value that activates this block.
REQ-002 Parameter CLK_HZ, default 50_000_000: clock frequency in Hz.
REQ-003 Parameter TICK_HZ, default 1000: internal tick rate; one tick = 1 ms at default.
REQ-004 Parameter ADDR_W, default 6: song-memory address width; NUM_NOTES = 2**ADDR_W.
REQ-005 Parameter NOTE_W, default 8: note code width. Parameter DUR_W, default 16: duration width, in ticks.
REQ-006 Parameter GAP_TICKS, default 20: silent ticks inserted after each note.
REQ-007 clock_50Mhz  in  1  sole clock; all logic on rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 currentState  in  5  state from the state controller.
REQ-010 pause  in  1  level; freezes playback while high.
REQ-011 mem_addr  out  ADDR_W  song-memory read address.
REQ-012 mem_note  in  NOTE_W  note code at mem_addr; valid exactly one cycle after mem_addr is driven.
REQ-013 mem_dur  in  DUR_W  note duration in ticks; 0 marks end of song.
REQ-014 note_code  out  NOTE_W  currently sounding note.
REQ-015 note_on  out  1  high while note_code is to be sounded.
REQ-016 stateComplete  out  1  song finished; held until deactivated.
REQ-017 debugString  out  32  {2'b0, fsm state[2:0], ADDR_W-padded index to 11 bits, DUR_W-bit remaining count truncated/padded to 16}.

Function
REQ-018 active = (currentState == STATE_ID); the FSM shall be in one of IDLE, FETCH, LOAD, PLAY, GAP, DONE.
REQ-019 IDLE: when active, go to FETCH with index 0; otherwise stay in IDLE.
REQ-020 FETCH: drive mem_addr = index; go to LOAD next cycle.
REQ-021 LOAD: sample mem_note/mem_dur; if mem_dur == 0, go to DONE; else latch note_code, remaining = mem_dur, clear prescaler, go to PLAY.
REQ-022 Tick: prescaler counts 0..CLK_HZ/TICK_HZ-1; a tick is the cycle it wraps. It advances only in PLAY/GAP with pause low.
REQ-023 PLAY: note_on = !pause; on each tick decrement remaining; on the tick where remaining == 1, load remaining = GAP_TICKS and go to GAP. If GAP_TICKS == 0, go directly to the next-note step of REQ-024.
REQ-024 GAP: note_on = 0; on the tick where remaining == 1, go to next-note: if index == NUM_NOTES-1, go to DONE; else index+1, go to FETCH.
REQ-025 DONE: note_on = 0, stateComplete = 1, hold until !active.
REQ-026 Deactivation: in any state, !active returns to IDLE next cycle with index = 0, note_on = 0 and stateComplete = 0; deactivation has priority over every other transition.
REQ-027 Pause: index, remaining, prescaler and state freeze; FETCH/LOAD still complete, and the FSM then holds in PLAY.
REQ-028 Index wrap is impossible; arithmetic is unsigned; remaining is DUR_W bits wide, with GAP_TICKS truncated to DUR_W.
REQ-029 Note-to-note latency: last GAP tick -> FETCH -> LOAD -> PLAY, i.e. note_on rises 2 cycles after the GAP-exit tick.

Reset
REQ-030 reset forces IDLE, index = 0, remaining = 0, prescaler = 0, note_code = 0, note_on = 0, stateComplete = 0 and mem_addr = 0 on the next edge.
REQ-031 reset has priority over deactivation and all transitions; mid-song reset discards progress.

Structure
REQ-032 The FSM state enum and a TICK_DIV = CLK_HZ/TICK_HZ helper constant shall live in shared package music_box_pkg.
REQ-033 The prescaler shall be a sub-module tick_generator (ports: clock_50Mhz, reset, enable, clear, tick).
REQ-034 The song memory is external; no ROM inside this block.

Verification (CLK_HZ=100, TICK_HZ=10, so 10 cycles/tick; GAP_TICKS=2, ADDR_W=2)
REQ-035 Memory {(5,3),(7,1),(0,0),…}, activate: note_code=5 with note_on for 30 cycles, 20-cycle gap, note 7 for 10 cycles, gap, then stateComplete=1.
REQ-036 All 4 entries nonzero: after entry 3 and its gap -> DONE without reading a 5th address; mem_addr never exceeds 3.
REQ-037 pause high for 25 cycles mid-note 5: note_on low during pause; total note_on time still 30 cycles.
REQ-038 currentState changes away during PLAY: next cycle note_on=0, stateComplete=0; re-activation restarts at index 0.
REQ-039 reset asserted in GAP while active: next cycle IDLE with all outputs 0; after release, song restarts from mem_addr=0.
REQ-040 First entry mem_dur=0: stateComplete=1 two cycles after activation, and note_on never asserts.
